ti_adc_framer: RTL and testbench

//  Next-gen TI-ADC sequencer/framer. Generates one-hot sub-ADC sample clocks over a runtime-selectable way count.

---
 rtl/ti_adc_pkg.sv | 25 ++
 rtl/ti_adc_frame_fifo.sv | 59 +++++
 rtl/ti_adc_framer.sv | 211 +++++++++++++++++++++
 tb/tb_ti_adc_framer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ti_adc_pkg.sv
// Shared types and helpers for the TI-ADC sequencer/framer.
// The optional offset-calibration path (TI_ADC_OFFSET_CAL_EN) uses sat_add.
package ti_adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } fsm_state_t;

    localparam int SEQ_W = 8;

    // Adds a signed offset to an unsigned sample and clamps into [0, max_val].
    function automatic int sat_add(input int raw, input int off, input int max_val);
        int sum;
        sum = raw + off;
        if (sum < 0) begin
            return 0;
        end else if (sum > max_val) begin
            return max_val;
        end
        return sum;
    endfunction

endpackage

// File: rtl/ti_adc_frame_fifo.sv
// Frame FIFO: DEPTH entries of {frame, seq}; full/empty come from pointers carrying a wrap bit.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ti_adc_frame_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Head is forced to zero when empty so stale storage never reaches the core.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/ti_adc_framer.sv
// TI-ADC sequencer/framer: one-hot sub-ADC pulses, per-lap frame assembly, frame FIFO to the core.
// Define TI_ADC_OFFSET_CAL_EN to add the cal_off port and a saturating offset stage (+1 latency).
module ti_adc_framer
    import ti_adc_pkg::*;
#(
    parameter int ADC_WAYS   = 8,
    parameter int ADC_BITS   = 9,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_INIT   = 0
) (
    input  logic                                  adc_clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic [$clog2(ADC_WAYS)-1:0]           ways_m1,
    input  logic [0:ADC_WAYS-1][0:ADC_BITS-1]     adc_data,
`ifdef TI_ADC_OFFSET_CAL_EN
    input  logic [0:ADC_WAYS-1][0:ADC_BITS-1]     cal_off,
`endif
    output logic [0:ADC_WAYS-1]                   subadc_clk,
    output logic [0:ADC_WAYS-1][0:ADC_BITS-1]     frame_data,
    output logic [SEQ_W-1:0]                      frame_seq,
    output logic                                  frame_valid,
    input  logic                                  frame_ready,
    output logic                                  ovf,
    input  logic                                  ovf_clr,
    output fsm_state_t                            dbg_state
);

    localparam int WAY_W   = $clog2(ADC_WAYS);
    localparam int FRAME_W = ADC_WAYS * ADC_BITS;
    localparam int ENTRY_W = FRAME_W + SEQ_W;
    localparam logic [WAY_W-1:0] INIT_PTR = WAY_W'(CLK_INIT);

    typedef logic [0:ADC_WAYS-1][0:ADC_BITS-1] frame_t;

    fsm_state_t         state_q, state_d;
    logic [WAY_W-1:0]   ptr_q, ptr_d;
    logic [WAY_W-1:0]   wm1_q, wm1_d;
    logic [WAY_W-1:0]   start_ptr;
    logic               cap_en;

    logic               cap_vld;
    logic               cap_last;
    logic [WAY_W-1:0]   cap_lane;
    logic [0:ADC_BITS-1] cap_val;

    frame_t             asm_q, asm_d;
    logic               push_q, push_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic               ovf_q, ovf_d;

    logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
    logic               fifo_full, fifo_empty;
    logic               pop, drop;

    assign start_ptr = (CLK_INIT > int'(ways_m1)) ? '0 : INIT_PTR;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wm1_d   = wm1_q;
        cap_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = PRIME;
                    wm1_d   = ways_m1;
                    ptr_d   = start_ptr;
                end
            end
            PRIME, RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    cap_en = (state_q == RUN);
                    if (ptr_q == wm1_q) begin
                        ptr_d   = '0;
                        state_d = RUN;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            wm1_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wm1_q   <= wm1_d;
        end
    end

    always_comb begin
        subadc_clk = '0;
        if (state_q != IDLE) begin
            subadc_clk[ptr_q] = 1'b1;
        end
    end

`ifdef TI_ADC_OFFSET_CAL_EN
    logic                cal_vld_q;
    logic                cal_last_q;
    logic [WAY_W-1:0]    cal_lane_q;
    logic [0:ADC_BITS-1] cal_val_q;
    int                  cal_sum;

    always_comb begin
        cal_sum = sat_add(int'(adc_data[ptr_q]), int'($signed(cal_off[ptr_q])),
                          (1 << ADC_BITS) - 1);
    end

    // Calibrated sample lands in the assembly register one cycle after its pulse.
    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            cal_vld_q  <= 1'b0;
            cal_last_q <= 1'b0;
            cal_lane_q <= '0;
            cal_val_q  <= '0;
        end else begin
            cal_vld_q  <= cap_en;
            cal_last_q <= (ptr_q == wm1_q);
            cal_lane_q <= ptr_q;
            cal_val_q  <= cal_sum[ADC_BITS-1:0];
        end
    end

    assign cap_vld  = cal_vld_q;
    assign cap_last = cal_last_q;
    assign cap_lane = cal_lane_q;
    assign cap_val  = cal_val_q;
`else
    assign cap_vld  = cap_en;
    assign cap_last = (ptr_q == wm1_q);
    assign cap_lane = ptr_q;
    assign cap_val  = adc_data[ptr_q];
`endif

    // Assembly is cleared on every start so lanes above ways_m1 stay zero for the whole run.
    always_comb begin
        asm_d  = asm_q;
        push_d = 1'b0;
        if ((state_q == IDLE) && en) begin
            asm_d = '0;
        end else if (cap_vld) begin
            asm_d[cap_lane] = cap_val;
            push_d          = cap_last;
        end
    end

    // Core handshake: a head transfers on any cycle where frame_valid && frame_ready;
    // frame_valid never depends on frame_ready.
    assign pop  = frame_valid && frame_ready;
    assign drop = push_q && fifo_full && !pop;

    always_comb begin
        seq_d = push_q ? seq_q + 1'b1 : seq_q;
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            asm_q  <= '0;
            push_q <= 1'b0;
            seq_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            asm_q  <= asm_d;
            push_q <= push_d;
            seq_q  <= seq_d;
            ovf_q  <= ovf_d;
        end
    end

    assign fifo_wdata = {asm_q, seq_q};

    ti_adc_frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (adc_clk),
        .rst_i   (rst),
        .push_i  (push_q),
        .pop_i   (pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {frame_data, frame_seq} = fifo_rdata;
    assign frame_valid = !fifo_empty;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_ti_adc_framer.sv
// Bench for ti_adc_framer: directed scenarios plus randomized traffic against a lap-schedule
// and frame-queue reference model.
module tb_ti_adc_framer;
    import ti_adc_pkg::*;

    localparam int WAYS     = 8;
    localparam int BITS     = 9;
    localparam int DEPTH    = 4;
    localparam int CLK_INIT = 0;
    localparam int EW       = WAYS * BITS + 8;

    typedef logic [0:WAYS-1][0:BITS-1] frame_t;

    logic       adc_clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       frame_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [2:0] ways_m1 = 3'd0;
    frame_t     adc_data = '0;
    logic [0:WAYS-1] subadc_clk;
    frame_t     frame_data;
    logic [7:0] frame_seq;
    logic       frame_valid;
    logic       ovf;
    fsm_state_t dbg_state;
`ifdef TI_ADC_OFFSET_CAL_EN
    frame_t     cal_off = '0;
`endif

    ti_adc_framer #(
        .ADC_WAYS   (WAYS),
        .ADC_BITS   (BITS),
        .FIFO_DEPTH (DEPTH),
        .CLK_INIT   (CLK_INIT)
    ) dut (
        .adc_clk     (adc_clk),
        .rst         (rst),
        .en          (en),
        .ways_m1     (ways_m1),
        .adc_data    (adc_data),
`ifdef TI_ADC_OFFSET_CAL_EN
        .cal_off     (cal_off),
`endif
        .subadc_clk  (subadc_clk),
        .frame_data  (frame_data),
        .frame_seq   (frame_seq),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr),
        .dbg_state   (dbg_state)
    );

    always #5 adc_clk = ~adc_clk;

    // Reference model: run flag, cycles since start, latched lap geometry, frame queue.
    logic [EW-1:0] exp_q[$];
    bit     m_run, m_pend, m_ovf;
    int     m_c, m_wm1, m_init, m_seq;
    frame_t m_asm, m_pend_frame;
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_ovf = 0;
        m_c = 0; m_wm1 = 0; m_init = 0; m_seq = 0;
        m_asm = '0; m_pend_frame = '0;
        exp_q.delete();
    endtask

    function automatic int way_at(int c);
        int p;
        p = m_wm1 + 1 - m_init;
        if (c < p) return m_init + c;
        return (c - p) % (m_wm1 + 1);
    endfunction

    function automatic logic [0:WAYS-1] exp_clk();
        logic [0:WAYS-1] v;
        v = '0;
        if (m_run) v[way_at(m_c)] = 1'b1;
        return v;
    endfunction

    task automatic rand_data();
        for (int k = 0; k < WAYS; k++) adc_data[k] = 9'($urandom_range(0, 511));
    endtask

    // One clock: the model consumes the inputs the DUT samples on this edge.
    task automatic tick();
        bit pop, drop;
        int way;
        @(posedge adc_clk);
        pop  = (exp_q.size() > 0) && frame_ready;
        drop = m_pend && (exp_q.size() == DEPTH) && !pop;
        if (pop) void'(exp_q.pop_front());
        if (m_pend && !drop) exp_q.push_back({m_pend_frame, 8'(m_seq)});
        if (m_pend) m_seq = (m_seq + 1) % 256;
        if (drop) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        m_pend = 0;
        if (m_run && en && (m_c >= m_wm1 + 1 - m_init)) begin
            way = way_at(m_c);
            m_asm[way] = adc_data[way];
            if (way == m_wm1) begin
                m_pend = 1;
                m_pend_frame = m_asm;
            end
        end
        if (!en) begin
            m_run = 0;
        end else if (!m_run) begin
            m_run = 1; m_c = 0; m_wm1 = int'(ways_m1);
            m_init = (CLK_INIT > m_wm1) ? 0 : CLK_INIT;
            m_asm = '0;
        end else begin
            m_c++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; frame_ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(posedge adc_clk);
        @(negedge adc_clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_checks++; if (subadc_clk !== '0) begin n_errors++; $display("FAIL reset_clk got %h exp 0", subadc_clk); end
        n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", frame_valid); end
        n_checks++; if (frame_data !== '0) begin n_errors++; $display("FAIL reset_data got %h exp 0", frame_data); end
        n_checks++; if (frame_seq !== 8'd0) begin n_errors++; $display("FAIL reset_seq got %0d exp 0", frame_seq); end
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL reset_state got %0d exp IDLE", dbg_state); end
        do_reset();
        tick();
        n_checks++; if (subadc_clk !== '0) begin n_errors++; $display("FAIL idle_clk got %h exp 0", subadc_clk); end
    endtask

    task automatic test_full_lap();
        frame_t exp_f;
        for (int k = 0; k < WAYS; k++) begin
            adc_data[k] = 9'(k * 10);
            exp_f[k]    = 9'(k * 10);
        end
        ways_m1 = 3'd7; frame_ready = 1'b1; en = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            tick();
            n_checks++;
            if (subadc_clk !== exp_clk()) begin n_errors++; $display("FAIL lap_clk n=%0d got %h exp %h", n, subadc_clk, exp_clk()); end
            n_checks++;
            if (frame_valid !== (exp_q.size() > 0)) begin n_errors++; $display("FAIL lap_valid n=%0d got %b exp %0d", n, frame_valid, exp_q.size()); end
            if (n == 1) begin
                n_checks++; if (subadc_clk !== 8'h80) begin n_errors++; $display("FAIL lap_first_pulse got %h exp 80", subadc_clk); end
            end
            if (n == 8) begin
                n_checks++; if (subadc_clk !== 8'h01) begin n_errors++; $display("FAIL lap_last_pulse got %h exp 01", subadc_clk); end
            end
            if (n == 17) begin
                n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL lap_early_valid got %b exp 0", frame_valid); end
            end
            if (n == 18) begin
                n_checks++; if (frame_valid !== 1'b1) begin n_errors++; $display("FAIL lap_latency got %b exp 1", frame_valid); end
                n_checks++; if (frame_data !== exp_f) begin n_errors++; $display("FAIL lap_frame got %h exp %h", frame_data, exp_f); end
                n_checks++; if (frame_seq !== 8'd0) begin n_errors++; $display("FAIL lap_seq got %0d exp 0", frame_seq); end
            end
        end
    endtask

    task automatic test_ways4();
        int vcount;
        vcount = 0;
        en = 1'b0;
        tick();
        ways_m1 = 3'd3; en = 1'b1; frame_ready = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            rand_data();
            tick();
            if (n == 1) ways_m1 = 3'd7;
            n_checks++;
            if (subadc_clk !== exp_clk()) begin n_errors++; $display("FAIL w4_clk n=%0d got %h exp %h", n, subadc_clk, exp_clk()); end
            n_checks++;
            if (subadc_clk[4:7] !== 4'b0) begin n_errors++; $display("FAIL w4_upper_clk n=%0d got %h exp 0", n, subadc_clk); end
            if (exp_q.size() > 0) begin
                n_checks++;
                if ({frame_data, frame_seq} !== exp_q[0]) begin n_errors++; $display("FAIL w4_head n=%0d got %h exp %h", n, {frame_data, frame_seq}, exp_q[0]); end
                n_checks++;
                if (frame_data[4:7] !== '0) begin n_errors++; $display("FAIL w4_upper_lanes n=%0d got %h exp 0", n, frame_data); end
            end
            if (n >= 20 && frame_valid === 1'b1) vcount++;
        end
        n_checks++;
        if (vcount !== 5) begin n_errors++; $display("FAIL w4_rate got %0d frames exp 5", vcount); end
    endtask

    task automatic test_overflow();
        int guard;
        do_reset();
        ways_m1 = 3'd1; en = 1'b1; frame_ready = 1'b0;
        guard = 0;
        while (m_seq != 5 && guard < 100) begin
            rand_data();
            tick();
            guard++;
        end
        n_checks++;
        if (guard >= 100) begin n_errors++; $display("FAIL ovf_timeout got %0d pushes exp 5", m_seq); end
        en = 1'b0;
        tick();
        n_checks++; if (ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_set got %b exp 1", ovf); end
        n_checks++; if (frame_valid !== 1'b1) begin n_errors++; $display("FAIL ovf_valid got %b exp 1", frame_valid); end
        n_checks++; if (frame_seq !== 8'd0) begin n_errors++; $display("FAIL ovf_head_seq got %0d exp 0", frame_seq); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL ovf_clr got %b exp 0", ovf); end
        frame_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (frame_seq !== 8'(i) || frame_valid !== 1'b1) begin n_errors++; $display("FAIL ovf_drain i=%0d got seq %0d valid %b exp seq %0d valid 1", i, frame_seq, frame_valid, i); end
            n_checks++;
            if ({frame_data, frame_seq} !== exp_q[0]) begin n_errors++; $display("FAIL ovf_drain_head i=%0d got %h exp %h", i, {frame_data, frame_seq}, exp_q[0]); end
            tick();
        end
        n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_empty got %b exp 0", frame_valid); end
        en = 1'b1;
        guard = 0;
        while (frame_valid !== 1'b1 && guard < 30) begin
            tick();
            guard++;
        end
        n_checks++;
        if (frame_seq !== 8'd5 || frame_valid !== 1'b1) begin n_errors++; $display("FAIL ovf_next_seq got seq %0d valid %b exp seq 5 valid 1", frame_seq, frame_valid); end
    endtask

    task automatic test_en_midlap();
        int early;
        early = 0;
        en = 1'b0; frame_ready = 1'b1;
        repeat (6) tick();
        ways_m1 = 3'd7; en = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            rand_data();
            tick();
            n_checks++;
            if (subadc_clk !== exp_clk()) begin n_errors++; $display("FAIL mid_clk n=%0d got %h exp %h", n, subadc_clk, exp_clk()); end
        end
        en = 1'b0;
        tick();
        n_checks++; if (subadc_clk !== '0) begin n_errors++; $display("FAIL mid_stop_clk got %h exp 0", subadc_clk); end
        n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL mid_stop_state got %0d exp IDLE", dbg_state); end
        en = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            rand_data();
            tick();
            n_checks++;
            if (subadc_clk !== exp_clk()) begin n_errors++; $display("FAIL mid_restart_clk n=%0d got %h exp %h", n, subadc_clk, exp_clk()); end
            if (n == 1) begin
                n_checks++; if (subadc_clk !== 8'h80) begin n_errors++; $display("FAIL mid_prime_repeat got %h exp 80", subadc_clk); end
            end
            if (n <= 17 && frame_valid === 1'b1) early++;
            if (exp_q.size() > 0) begin
                n_checks++;
                if ({frame_data, frame_seq} !== exp_q[0]) begin n_errors++; $display("FAIL mid_head n=%0d got %h exp %h", n, {frame_data, frame_seq}, exp_q[0]); end
            end
        end
        n_checks++;
        if (early !== 0) begin n_errors++; $display("FAIL mid_partial_frame got %0d early frames exp 0", early); end
    endtask

    task automatic test_rst_midrun();
        ways_m1 = 3'd1; en = 1'b1; frame_ready = 1'b0;
        repeat (20) begin
            rand_data();
            tick();
        end
        @(posedge adc_clk);
        #3 rst = 1'b1;
        #1;
        n_checks++; if (subadc_clk !== '0) begin n_errors++; $display("FAIL rst_clk got %h exp 0", subadc_clk); end
        n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid got %b exp 0", frame_valid); end
        n_checks++; if (frame_data !== '0 || frame_seq !== 8'd0) begin n_errors++; $display("FAIL rst_head got %h/%0d exp 0/0", frame_data, frame_seq); end
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL rst_ovf got %b exp 0", ovf); end
        en = 1'b0;
        @(negedge adc_clk);
        rst = 1'b0;
        model_reset();
        tick();
        n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL rst_fifo_empty got %b exp 0", frame_valid); end
    endtask

    task automatic test_random();
        ways_m1 = 3'($urandom_range(0, 7));
        en = 1'b1;
        for (int t = 0; t < 800; t++) begin
            rand_data();
            ways_m1     = 3'($urandom_range(0, 7));
            frame_ready = ($urandom_range(0, 1) == 1);
            ovf_clr     = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            tick();
            n_checks++;
            if (subadc_clk !== exp_clk()) begin n_errors++; $display("FAIL rand_clk t=%0d got %h exp %h", t, subadc_clk, exp_clk()); end
            n_checks++;
            if (frame_valid !== (exp_q.size() > 0)) begin n_errors++; $display("FAIL rand_valid t=%0d got %b exp %0d", t, frame_valid, exp_q.size()); end
            if (exp_q.size() > 0) begin
                n_checks++;
                if ({frame_data, frame_seq} !== exp_q[0]) begin n_errors++; $display("FAIL rand_head t=%0d got %h exp %h", t, {frame_data, frame_seq}, exp_q[0]); end
            end
            n_checks++;
            if (ovf !== m_ovf) begin n_errors++; $display("FAIL rand_ovf t=%0d got %b exp %b", t, ovf, m_ovf); end
        end
        ovf_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_lap();
        test_ways4();
        test_overflow();
        test_en_midlap();
        test_rst_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
